// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and request-unit FSM states.
package cpu_types_pkg;
  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2,
    HALTED  = 2'd3
  } ru_state_t;
endpackage

// File: rtl/ru_wait_counter.sv
// Counts consecutive wait cycles of one memory access; expired flags the TIMEOUT-th wait.
module ru_wait_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Fires on the wait cycle that would bring the count up to TIMEOUT.
  assign expired = inc && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr || expired) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/request_unit.sv
// Arbitrates instruction fetch and data load/store onto one memory port,
// returning one-cycle hit pulses, with a wait watchdog and a sticky halt.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_word_en,
  input  logic              store_word_en,
  input  logic              halt,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic [WORD_W-1:0] mem_load,
  input  logic              mem_ready,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_store,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] dload,
  output logic              halted,
  output logic              timeout_err
);
  ru_state_t state;
  logic      data_done;
  logic      is_load;
  logic      busy;
  logic      wait_clr;
  logic      wait_inc;
  logic      expired;

  assign busy     = (state == IFETCH) || (state == DACCESS);
  assign wait_inc = busy && !mem_ready;
  assign wait_clr = busy && mem_ready;

  ru_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      data_done   <= 1'b0;
      is_load     <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_store   <= '0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      instr       <= '0;
      dload       <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          // data_done keeps a finished data access from being reissued
          // while the control unit still presents the same instruction.
          if ((load_word_en || store_word_en) && !data_done) begin
            state     <= DACCESS;
            mem_addr  <= daddr;
            mem_store <= dstore;
            mem_wen   <= store_word_en;
            mem_ren   <= !store_word_en;
            is_load   <= load_word_en && !store_word_en;
          end else if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state     <= IFETCH;
            mem_addr  <= iaddr;
            mem_store <= dstore;
            mem_ren   <= 1'b1;
            mem_wen   <= 1'b0;
          end
        end
        IFETCH: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_ren   <= 1'b0;
            instr     <= mem_load;
            ihit      <= 1'b1;
            data_done <= 1'b0;
          end else if (expired) begin
            state       <= IDLE;
            mem_ren     <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        DACCESS: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            dhit      <= 1'b1;
            data_done <= 1'b1;
            if (is_load) dload <= mem_load;
          end else if (expired) begin
            state       <= IDLE;
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          // HALTED: frozen until reset
        end
      endcase
    end
  end
endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: per-cycle reference model plus literal spot checks.
module tb_request_unit;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_word_en = 1'b0;
  logic        store_word_en = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] mem_load = '0;
  logic        mem_ready = 1'b0;
  logic        mem_ren, mem_wen, ihit, dhit, halted, timeout_err;
  logic [31:0] mem_addr, mem_store, instr, dload;

  request_unit #(.WORD_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .load_word_en(load_word_en), .store_word_en(store_word_en), .halt(halt),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .mem_load(mem_load), .mem_ready(mem_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store),
    .ihit(ihit), .dhit(dhit), .instr(instr), .dload(dload),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: which access is outstanding and how long it has waited.
  int          m_kind = 0;   // 0 none, 1 fetch, 2 data
  int          m_waits = 0;
  bit          m_st = 0, m_ld = 0, m_done = 0, m_halted = 0, m_terr = 0;
  bit          m_ihit = 0, m_dhit = 0;
  logic [31:0] m_addr = '0, m_store = '0, m_instr = '0, m_dload = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_kind = 0; m_waits = 0; m_st = 0; m_ld = 0; m_done = 0;
      m_halted = 0; m_terr = 0; m_ihit = 0; m_dhit = 0;
      m_addr = '0; m_store = '0; m_instr = '0; m_dload = '0;
    end else begin
      m_ihit = 0;
      m_dhit = 0;
      if (m_halted) begin
        m_kind = 0;
      end else if (m_kind == 0) begin
        m_waits = 0;
        if ((load_word_en || store_word_en) && !m_done) begin
          m_kind = 2; m_st = store_word_en; m_ld = load_word_en && !store_word_en;
          m_addr = daddr; m_store = dstore;
        end else if (halt) begin
          m_halted = 1;
        end else begin
          m_kind = 1; m_st = 0; m_addr = iaddr; m_store = dstore;
        end
      end else if (mem_ready) begin
        if (m_kind == 1) begin
          m_instr = mem_load; m_ihit = 1; m_done = 0;
        end else begin
          if (m_ld) m_dload = mem_load;
          m_dhit = 1; m_done = 1;
        end
        m_kind = 0;
      end else begin
        m_waits++;
        if (m_waits == TO) begin
          m_terr = 1;
          m_kind = 0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    check("cyc_mem_ren", mem_ren, (m_kind == 1) || (m_kind == 2 && !m_st));
    check("cyc_mem_wen", mem_wen, m_kind == 2 && m_st);
    check("cyc_mem_addr", mem_addr, m_addr);
    check("cyc_mem_store", mem_store, m_store);
    check("cyc_ihit", ihit, m_ihit);
    check("cyc_dhit", dhit, m_dhit);
    check("cyc_instr", instr, m_instr);
    check("cyc_dload", dload, m_dload);
    check("cyc_halted", halted, m_halted);
    check("cyc_timeout_err", timeout_err, m_terr);
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Acts as the memory: waits for a request, holds mem_ready low for `delay`
  // cycles while checking the request stays put, then completes it.
  task automatic serve(input int delay, input logic [31:0] data, input logic [31:0] exp_addr,
                       input bit exp_wr, input logic [31:0] exp_store, input string nm);
    int n = 0;
    while (!(mem_ren || mem_wen) && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_request_seen"}, mem_ren || mem_wen, 1);
    for (int i = 0; i <= delay; i++) begin
      check({nm, "_addr"}, mem_addr, exp_addr);
      check({nm, "_wen"}, mem_wen, exp_wr);
      check({nm, "_ren"}, mem_ren, !exp_wr);
      if (exp_wr) check({nm, "_store"}, mem_store, exp_store);
      if (i == delay) begin
        mem_ready = 1'b1;
        mem_load  = data;
      end
      tick();
    end
    mem_ready = 1'b0;
    check({nm, "_ihit"}, ihit, !(exp_wr || exp_addr == daddr && (load_word_en || store_word_en)) ? 1 : 0);
    check({nm, "_dhit"}, dhit, (exp_wr || exp_addr == daddr && (load_word_en || store_word_en)) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_halted", halted, 0);
    iaddr = 32'h40;
    RST = 1'b0;

    // Fetch with two wait cycles
    serve(2, 32'h8C220004, 32'h40, 0, 0, "fetch1");
    check("fetch1_instr", instr, 32'h8C220004);
    check("fetch1_ren_drop", mem_ren, 0);
    load_word_en = 1'b1; daddr = 32'h100; iaddr = 32'h44;
    tick();
    check("fetch1_single_pulse", ihit, 0);

    // Load goes ahead of the next fetch and is not reissued
    serve(0, 32'hDEADBEEF, 32'h100, 0, 0, "load");
    check("load_dload", dload, 32'hDEADBEEF);
    tick();
    check("load_single_pulse", dhit, 0);
    check("load_no_reissue_addr", mem_addr, 32'h44);
    check("load_no_reissue_ren", mem_ren, 1);
    serve(0, 32'h00000013, 32'h44, 0, 0, "fetch2");

    // Store held stable across three wait cycles
    load_word_en = 1'b0; store_word_en = 1'b1; daddr = 32'h104; dstore = 32'h1234;
    serve(3, 32'h0, 32'h104, 1, 32'h1234, "store");
    store_word_en = 1'b0;
    check("store_dload_kept", dload, 32'hDEADBEEF);
    serve(0, 32'h00000014, 32'h44, 0, 0, "fetch3");

    // Load and store together: store wins, dload untouched
    load_word_en = 1'b1; store_word_en = 1'b1; daddr = 32'h108; dstore = 32'h55AA;
    serve(1, 32'h11112222, 32'h108, 1, 32'h55AA, "ldst");
    check("ldst_dload_kept", dload, 32'hDEADBEEF);
    load_word_en = 1'b0; store_word_en = 1'b0;

    // Watchdog: fetch never acknowledged
    tick();
    check("to_req", mem_ren, 1);
    repeat (3) tick();
    check("to_not_yet", timeout_err, 0);
    check("to_still_req", mem_ren, 1);
    tick();
    check("to_fired", timeout_err, 1);
    check("to_dropped", mem_ren, 0);
    check("to_no_hit", ihit, 0);
    tick();
    check("to_reissue_ren", mem_ren, 1);
    check("to_reissue_addr", mem_addr, 32'h44);
    serve(0, 32'h0000ABCD, 32'h44, 0, 0, "to_retry");

    // Halt arriving mid-fetch waits for the fetch to finish
    tick();
    halt = 1'b1;
    serve(1, 32'h0000000C, 32'h44, 0, 0, "halt_fetch");
    check("halt_not_yet", halted, 0);
    tick();
    check("halt_set", halted, 1);
    mem_ready = 1'b1; load_word_en = 1'b1;
    repeat (3) tick();
    check("halt_frozen_ren", mem_ren, 0);
    check("halt_frozen_wen", mem_wen, 0);
    check("halt_sticky", halted, 1);
    mem_ready = 1'b0;

    // Reset clears halt; then reset lands mid data access
    RST = 1'b1;
    tick();
    RST = 1'b0; halt = 1'b0; daddr = 32'h180;
    serve(0, 32'h00000077, 32'h180, 0, 0, "post_rst_load");
    serve(0, 32'h00000099, 32'h44, 0, 0, "post_rst_fetch");
    daddr = 32'h200;
    tick();
    check("mid_req_ren", mem_ren, 1);
    check("mid_req_addr", mem_addr, 32'h200);
    #2;
    RST = 1'b1;
    #1;
    check("async_mem_ren", mem_ren, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_instr", instr, 0);
    check("async_dload", dload, 0);
    check("async_halted", halted, 0);
    check("async_timeout_err", timeout_err, 0);
    tick();
    RST = 1'b0; load_word_en = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
